conv_writeback: RTL and testbench

Output-side writer for the convolution layer. It consumes the 8-bit pixel stream produced by the layer (`out_data`/`out_rdy`/`conv_done`) and packs 32 consecutive pixels into a 256-bit word. It writes each word to the memory bus through a valid/acknowledge handshake at sequential word addresses starting from a programmed base. It mirrors the layer's 256-bit read path and sits between the convolution top level and output memory.

---
 rtl/conv_writeback.sv | 185 ++++++++++++++++++
 tb/tb_conv_writeback.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_writeback.sv
`default_nettype none
// ============================================================================
// Module   : conv_writeback
// Brief    : Packs the convolution layer's 8-bit pixel stream into 256-bit
//            words and writes them at sequential addresses over a valid/ack
//            bus. Optional byte-enable output under CONV_WB_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_writeback #(
    parameter int ADDR_W = 20,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [7:0]        in_data,
    input  logic              in_rdy,
    input  logic              in_done,
    output logic [ADDR_W-1:0] w_addr,
    output logic [255:0]      w_data,
`ifdef CONV_WB_MASK_EN
    output logic [31:0]       w_mask,
`endif
    output logic              w_en,
    input  logic              w_ack,
    output logic              out_done,
    output logic              out_ovf
);

    localparam int            c_PW     = $clog2(QDEPTH);
    localparam logic [c_PW:0] c_QDEPTH = (c_PW+1)'(QDEPTH);
    localparam logic [1:0]    c_IDLE   = 2'd0;
    localparam logic [1:0]    c_FILL   = 2'd1;
    localparam logic [1:0]    c_FLUSH  = 2'd2;
    localparam logic [1:0]    c_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [4:0]        r_cnt;
    logic [255:0]      r_pack;
    logic [ADDR_W-1:0] r_addr;
    logic [c_PW:0]     r_wr;
    logic [c_PW:0]     r_rd;
    logic              r_done;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_q_addr [QDEPTH];
    logic [255:0]      r_q_data [QDEPTH];
`ifdef CONV_WB_MASK_EN
    logic [31:0]       r_q_mask [QDEPTH];
    logic [31:0]       w_push_mask;
`endif

    logic              w_pop;
    logic              w_push;
    logic              w_slot;
    logic              w_ovf_set;
    logic              w_flush;
    logic              w_drained;
    logic [4:0]        w_cnt_nx;
    logic [255:0]      w_pack_nx;
    logic [255:0]      w_push_data;
    logic [c_PW:0]     w_qcnt;
    logic [c_PW:0]     w_qcnt_nx;

    assign w_en     = (r_wr != r_rd);
    assign w_addr   = r_q_addr[r_rd[c_PW-1:0]];
    assign w_data   = r_q_data[r_rd[c_PW-1:0]];
`ifdef CONV_WB_MASK_EN
    assign w_mask   = r_q_mask[r_rd[c_PW-1:0]];
`endif
    assign out_done = r_done;
    assign out_ovf  = r_ovf;

    assign w_pop  = w_en & w_ack;
    assign w_qcnt = r_wr - r_rd;
    // A pop in the same cycle frees the slot a push needs.
    assign w_slot = (w_qcnt != c_QDEPTH) || w_pop;

    always_comb begin
        w_cnt_nx    = r_cnt;
        w_pack_nx   = r_pack;
        w_push      = 1'b0;
        w_push_data = '0;
`ifdef CONV_WB_MASK_EN
        w_push_mask = '0;
`endif
        w_ovf_set   = 1'b0;
        if (r_state == c_FILL && in_rdy) begin
            if (r_cnt == 5'd31) begin
                if (w_slot) begin
                    w_push      = 1'b1;
                    w_push_data = {in_data, r_pack[247:0]};
`ifdef CONV_WB_MASK_EN
                    w_push_mask = 32'hFFFF_FFFF;
`endif
                    w_cnt_nx    = 5'd0;
                    w_pack_nx   = '0;
                end else begin
                    w_ovf_set   = 1'b1;
                end
            end else begin
                w_pack_nx[{r_cnt, 3'b000} +: 8] = in_data;
                w_cnt_nx = r_cnt + 5'd1;
            end
        end
        // Flush sees the byte packed this cycle, so a same-cycle byte is included.
        w_flush = (r_state == c_FILL && in_done) || (r_state == c_FLUSH);
        if (w_flush && (w_cnt_nx != 5'd0) && !w_push && w_slot) begin
            w_push      = 1'b1;
            w_push_data = w_pack_nx;
`ifdef CONV_WB_MASK_EN
            w_push_mask = ~(32'hFFFF_FFFF << w_cnt_nx);
`endif
            w_cnt_nx    = 5'd0;
            w_pack_nx   = '0;
        end
        w_qcnt_nx = w_qcnt + {{c_PW{1'b0}}, w_push} - {{c_PW{1'b0}}, w_pop};
        w_drained = (w_qcnt_nx == '0) && (w_cnt_nx == 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 5'd0;
            r_pack  <= '0;
            r_addr  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_addr[i] <= '0;
                r_q_data[i] <= '0;
`ifdef CONV_WB_MASK_EN
                r_q_mask[i] <= '0;
`endif
            end
        end else begin
            r_cnt  <= w_cnt_nx;
            r_pack <= w_pack_nx;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_q_addr[r_wr[c_PW-1:0]] <= r_addr;
                r_q_data[r_wr[c_PW-1:0]] <= w_push_data;
`ifdef CONV_WB_MASK_EN
                r_q_mask[r_wr[c_PW-1:0]] <= w_push_mask;
`endif
                r_wr   <= r_wr + 1'b1;
                r_addr <= r_addr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (in_start) begin
                        r_state <= c_FILL;
                        r_addr  <= in_base;
                        r_cnt   <= 5'd0;
                        r_pack  <= '0;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                c_FILL: begin
                    if (in_done) begin
                        r_state <= w_drained ? c_DONE : c_FLUSH;
                        r_done  <= w_drained;
                    end
                end
                c_FLUSH: begin
                    if (w_drained) begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_writeback
// Brief    : Directed scoreboard bench for conv_writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_writeback;

    localparam int ADDR_W = 20;
    localparam int QDEPTH = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [255:0]      data;
        logic [31:0]       mask;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_start;
    logic [ADDR_W-1:0] in_base;
    logic [7:0]        in_data;
    logic              in_rdy;
    logic              in_done;
    logic [ADDR_W-1:0] w_addr;
    logic [255:0]      w_data;
    logic [31:0]       w_mask;
    logic              w_en;
    logic              w_ack;
    logic              out_done;
    logic              out_ovf;

    int tests = 0;
    int fails = 0;
    int n_writes = 0;
    wr_t sb[$];

    logic [ADDR_W-1:0] m_addr;
    logic [255:0]      m_pack;
    int                m_cnt;

    always #5 clk = ~clk;

    conv_writeback #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_base(in_base),
        .in_data(in_data), .in_rdy(in_rdy), .in_done(in_done),
        .w_addr(w_addr), .w_data(w_data),
`ifdef CONV_WB_MASK_EN
        .w_mask(w_mask),
`endif
        .w_en(w_en), .w_ack(w_ack), .out_done(out_done), .out_ovf(out_ovf)
    );
`ifndef CONV_WB_MASK_EN
    assign w_mask = 32'hFFFF_FFFF;
`endif

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard check on every accepted write.
    always @(negedge clk) begin
        if (!rst && w_en && w_ack) begin
            wr_t e;
            n_writes++;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed addr %0h expected no write", w_addr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 256'(w_addr), 256'(e.addr));
                chk("wr_data", w_data, e.data);
`ifdef CONV_WB_MASK_EN
                chk("wr_mask", 256'(w_mask), 256'(e.mask));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_byte(input logic [7:0] b);
        wr_t e;
        m_pack[m_cnt*8 +: 8] = b;
        m_cnt++;
        if (m_cnt == 32) begin
            e.addr = m_addr; e.data = m_pack; e.mask = 32'hFFFF_FFFF;
            sb.push_back(e);
            m_addr++; m_pack = '0; m_cnt = 0;
        end
    endtask

    task automatic m_flush();
        wr_t e;
        if (m_cnt > 0) begin
            e.addr = m_addr; e.data = m_pack;
`ifdef CONV_WB_MASK_EN
            e.mask = (32'h1 << m_cnt) - 32'h1;
`else
            e.mask = 32'hFFFF_FFFF;
`endif
            sb.push_back(e);
            m_addr++; m_pack = '0; m_cnt = 0;
        end
    endtask

    task automatic start(input logic [ADDR_W-1:0] base);
        in_start = 1'b1; in_base = base;
        tick();
        in_start = 1'b0;
        m_addr = base; m_pack = '0; m_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit model);
        in_rdy = 1'b1; in_data = b;
        if (model) m_byte(b);
        tick();
        in_rdy = 1'b0;
    endtask

    task automatic finish_image(input int budget);
        int n;
        in_done = 1'b1;
        m_flush();
        tick();
        in_done = 1'b0;
        n = 0;
        while (out_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", 256'(out_done), 256'(1));
        chk("sb_drained", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        int w0;
        rst = 1'b1; in_start = 0; in_base = '0; in_data = '0;
        in_rdy = 0; in_done = 0; w_ack = 0;
        m_addr = '0; m_pack = '0; m_cnt = 0;
        tick(); tick();
        chk("rst_w_en", 256'(w_en), 256'(0));
        chk("rst_w_addr", 256'(w_addr), 256'(0));
        chk("rst_w_data", w_data, 256'(0));
`ifdef CONV_WB_MASK_EN
        chk("rst_w_mask", 256'(w_mask), 256'(0));
`endif
        chk("rst_out_done", 256'(out_done), 256'(0));
        chk("rst_out_ovf", 256'(out_ovf), 256'(0));
        rst = 1'b0;
        tick();

        // Two full words, ack held high.
        start(20'h00100);
        w_ack = 1'b1;
        for (int i = 0; i < 64; i++) send(8'(i), 1'b1);
        tick(); tick(); tick();
        chk("t1_sb_empty", 256'(sb.size()), 256'(0));
        chk("t1_writes", 256'(n_writes), 256'(2));
        chk("t1_no_done", 256'(out_done), 256'(0));
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        chk("t1_done_cnt0", 256'(out_done), 256'(1));

        // 40 bytes then a partial flush; done one cycle after its ack.
        start(20'h00100);
        chk("t2_done_cleared", 256'(out_done), 256'(0));
        for (int i = 0; i < 40; i++) send(8'(8'h40 + i), 1'b1);
        tick(); tick();
        w_ack = 1'b0;
        in_done = 1'b1;
        m_flush();
        tick();
        in_done = 1'b0;
        chk("t2_partial_w_en", 256'(w_en), 256'(1));
        chk("t2_partial_addr", 256'(w_addr), 256'(20'h00101));
        chk("t2_done_before_ack", 256'(out_done), 256'(0));
        w_ack = 1'b1;
        tick();
        chk("t2_done_after_ack", 256'(out_done), 256'(1));
        chk("t2_w_en_idle", 256'(w_en), 256'(0));

        // Overflow: queue full, pack holds 31 bytes, no ack.
        start(20'h00200);
        w_ack = 1'b0;
        for (int i = 0; i < QDEPTH*32 + 31; i++) send(8'(i), 1'b1);
        chk("t3_no_ovf_yet", 256'(out_ovf), 256'(0));
        send(8'hEE, 1'b0);
        chk("t3_ovf_set", 256'(out_ovf), 256'(1));
        w0 = n_writes;
        w_ack = 1'b1;
        for (int i = 0; i < QDEPTH + 2; i++) tick();
        send(8'hAB, 1'b1);
        tick(); tick();
        chk("t3_writes", 256'(n_writes - w0), 256'(QDEPTH + 1));
        chk("t3_ovf_sticky", 256'(out_ovf), 256'(1));
        finish_image(20);

        // Address wrap.
        start(20'hFFFFF);
        chk("t4_ovf_cleared", 256'(out_ovf), 256'(0));
        for (int i = 0; i < 64; i++) send(8'(8'hC0 ^ i), 1'b1);
        finish_image(20);

        // Asynchronous reset with a pending write.
        start(20'h00300);
        w_ack = 1'b0;
        for (int i = 0; i < 32; i++) send(8'(i * 3), 1'b1);
        chk("t5_w_en_latency", 256'(w_en), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_w_en", 256'(w_en), 256'(0));
        chk("t5_async_w_addr", 256'(w_addr), 256'(0));
        chk("t5_async_w_data", w_data, 256'(0));
        chk("t5_async_ovf", 256'(out_ovf), 256'(0));
        sb.delete();
        tick();
        rst = 1'b0;
        w_ack = 1'b1;
        tick(); tick();
        chk("t5_idle_after_rst", 256'(w_en), 256'(0));
        start(20'h00310);
        for (int i = 0; i < 31; i++) send(8'(i), 1'b1);
        chk("t5_no_word_at_31", 256'(w_en), 256'(0));
        send(8'h99, 1'b1);
        chk("t5_word_at_32", 256'(w_en), 256'(1));
        tick();
        chk("t5_sb_empty", 256'(sb.size()), 256'(0));
        finish_image(20);

        // in_rdy and in_done together on the 32nd byte.
        start(20'h00400);
        for (int i = 0; i < 31; i++) send(8'(8'h80 + i), 1'b1);
        w0 = n_writes;
        in_rdy = 1'b1; in_data = 8'h5A; in_done = 1'b1;
        m_byte(8'h5A);
        m_flush();
        tick();
        in_rdy = 1'b0; in_done = 1'b0;
        chk("t6_w_en", 256'(w_en), 256'(1));
        chk("t6_done_before_ack", 256'(out_done), 256'(0));
        tick();
        chk("t6_done_after_ack", 256'(out_done), 256'(1));
        tick(); tick(); tick();
        chk("t6_single_write", 256'(n_writes - w0), 256'(1));
        chk("t6_sb_empty", 256'(sb.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed no end expected end");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
